digct_event_capture: RTL and testbench
======================================

// Module: digct_event_capture
// PURPOSE
//  Downstream consumer of the DigCt registered outputs OUT1..OUT3.
//  Watches the 3-bit vector, detects any change, and timestamps it.
//  Queues each change event in a small FIFO, drained by a valid/ready interface.
//  Also keeps a saturating change counter and a sticky overflow flag for debug readout.
// PARAMETERS
//  DATA_W  3  width of monitored vector (OUT1=bit0, OUT2=bit1, OUT3=bit2)
//  DEPTH   4  FIFO entries; power of two, >=2
//  TS_W    8  timestamp counter width
//  CNT_W   8  change counter width
// PORTS
//  clk        in   1               single clock, all state updates on posedge
//  rst        in   1               synchronous, active-high reset
//  in_vec     in   DATA_W          {OUT3,OUT2,OUT1} from DigCt, already registered
//  clr        in   1               sync clear of evt_count and overflow (FIFO untouched)
//  evt_valid  out  1               FIFO non-empty
//  evt_ready  in   1               consumer accepts head entry
//  evt_data   out  TS_W+DATA_W     head entry {ts, value}
//  evt_count  out  CNT_W           saturating count of detected changes
//  overflow   out  1               sticky: an event was dropped (FIFO full)
//  fifo_level out  $clog2(DEPTH)+1 current occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0, FIFO empty, ts=0, prev_q=0, FSM->INIT.
//  rst overrides everything, including mid-operation: FIFO is flushed; evt_valid=0 after that edge.
//  FSM states:
//   INIT: load prev_q<=in_vec, no event generated -> ARMED next cycle.
//   ARMED: change = (in_vec != prev_q); prev_q<=in_vec every cycle.
//  Timestamp ts: increments every cycle from 0 after reset; wraps 2^TS_W-1 -> 0.
//  An entry captures the ts value current in the detect cycle.
//  Push: on change in ARMED, entry {ts, in_vec} is written at that posedge.
//   Latency: evt_valid is high the cycle after the detecting edge if the FIFO was empty.
//  Pop: evt_valid & evt_ready at posedge removes head.
//   evt_ready with FIFO empty has no effect.
//  Full + push, no pop: entry dropped, overflow<=1; evt_count still increments.
//  Full + push + pop same edge: pop and push both occur; level stays DEPTH; no overflow.
//  Empty + push + pop: no pop occurs (evt_valid=0); level becomes 1.
//  evt_data is valid only while evt_valid=1.
//   It holds stable while evt_valid=1 and evt_ready=0.
//  evt_count: +1 per change, saturating at 2^CNT_W-1.
//   clr=1 zeroes it; clr and change on the same edge -> result 0.
//   overflow follows the same rule: clr wins over set.
//  Pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
// STRUCTURE
//  Package digct_pkg: DATA_W/TS_W defaults, FSM state enum {INIT,ARMED}, entry width localparam.
//  Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/level).
//   Instantiated once.
//  Top level holds the FSM, prev_q, ts, evt_count and overflow.
// TESTING
//  1 Reset then in_vec held 3'b101 for 10 cycles -> no event; evt_valid=0; evt_count=0.
//  2 ARMED, in_vec 000->011 at ts=5, evt_ready=1 -> evt_valid 1 cycle later, evt_data={8'd5,3'b011}, popped, evt_count=1.
//  3 evt_ready=0, 6 consecutive changes, DEPTH=4 -> level=4, overflow=1, evt_count=6; drained entries are the first 4 in order.
//  4 FIFO full, change and evt_ready=1 on same edge -> level stays 4, overflow stays 0, new entry at tail.
//  5 Assert clr on a change edge with evt_count=7, overflow=1 -> both read 0; FIFO contents unchanged.
//  6 rst mid-stream with level=3 -> next cycle evt_valid=0, level=0, ts=0; first post-reset value produces no event.

Source files
------------

// File: rtl/digct_pkg.sv
// Shared definitions for the DigCt event-capture block.
// Contents:
//   DATA_W_DEF, TS_W_DEF  default widths of the monitored vector and timestamp
//   ENTRY_W_DEF           width of one queued event entry {ts, value}
//   state_t               capture FSM states (INIT, ARMED)
package digct_pkg;

    localparam int DATA_W_DEF  = 3;
    localparam int TS_W_DEF    = 8;
    localparam int ENTRY_W_DEF = TS_W_DEF + DATA_W_DEF;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding captured event entries.
// Ports:
//   clk    in   clock, all updates on posedge
//   rst    in   synchronous active-high reset; empties the FIFO
//   push   in   write wdata at the tail (ignored when full unless popping)
//   wdata  in   WIDTH-bit entry to write
//   pop    in   remove the head entry (ignored when empty)
//   rdata  out  head entry, meaningful only while empty=0
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   level  out  occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra MSB: equal low bits with differing MSB means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/digct_event_capture.sv
// Change detector and timestamped event queue for the DigCt outputs OUT1..OUT3.
// Ports:
//   clk         in   clock, all updates on posedge
//   rst         in   synchronous active-high reset (flushes FIFO, ts=0, FSM->INIT)
//   in_vec      in   {OUT3,OUT2,OUT1}, already registered upstream
//   clr         in   synchronous clear of evt_count and overflow (FIFO untouched)
//   evt_valid   out  FIFO non-empty
//   evt_ready   in   consumer accepts the head entry
//   evt_data    out  head entry {ts, value}
//   evt_count   out  saturating count of detected changes
//   overflow    out  sticky flag: a change was dropped because the FIFO was full
//   fifo_level  out  FIFO occupancy 0..DEPTH
module digct_event_capture
    import digct_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int TS_W   = TS_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_vec,
    input  logic                      clr,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [TS_W+DATA_W-1:0]    evt_data,
    output logic [CNT_W-1:0]          evt_count,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int ENTRY_W = TS_W + DATA_W;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   prev_q;
    logic [TS_W-1:0]     ts_q;
    logic [CNT_W-1:0]    count_q;
    logic                ovf_q;
    logic                change;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    // INIT only seeds prev_q so the first value after reset is never an event.
    always_comb begin
        state_d = state_q;
        change  = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_ARMED;
            ST_ARMED: change  = (in_vec != prev_q);
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            ts_q   <= '0;
        end else begin
            prev_q <= in_vec;
            ts_q   <= ts_q + 1'b1;
        end
    end

    // A change is lost only if the FIFO is full and the head is not leaving this edge.
    assign drop = change & fifo_full & ~evt_ready;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (change) count_q <= sat_inc(count_q);
            if (drop)   ovf_q   <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .wdata ({ts_q, in_vec}),
        .pop   (evt_ready),
        .rdata (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_digct_event_capture.sv
module tb_digct_event_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_vec;
    logic        clr;
    logic        evt_valid;
    logic        evt_ready;
    logic [10:0] evt_data;
    logic [7:0]  evt_count;
    logic        overflow;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    digct_event_capture dut (
        .clk        (clk),
        .rst        (rst),
        .in_vec     (in_vec),
        .clr        (clr),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string       nm;
        logic        r;
        logic [2:0]  iv;
        logic        rdy;
        logic        cl;
        logic        ev;
        logic [10:0] ed;
        logic [7:0]  ec;
        logic        eo;
        logic [2:0]  el;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    endtask

    function automatic void add(input string nm, input logic r, input logic [2:0] iv,
                                input logic rdy, input logic cl, input logic ev,
                                input logic [10:0] ed, input logic [7:0] ec,
                                input logic eo, input logic [2:0] el);
        vec_t v;
        v.nm = nm; v.r = r; v.iv = iv; v.rdy = rdy; v.cl = cl;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.el = el;
        vq.push_back(v);
    endfunction

    // Drive inputs for the next edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic [2:0] iv, input logic rdy, input logic cl);
        rst = r; in_vec = iv; evt_ready = rdy; clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic ev, input logic [10:0] ed,
                              input logic [7:0] ec, input logic eo, input logic [2:0] el);
        chk({nm, ".valid"}, {31'd0, evt_valid}, {31'd0, ev});
        if (ev) chk({nm, ".data"}, {21'd0, evt_data}, {21'd0, ed});
        chk({nm, ".count"}, {24'd0, evt_count}, {24'd0, ec});
        chk({nm, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({nm, ".level"}, {29'd0, fifo_level}, {29'd0, el});
    endtask

    initial begin
        rst = 1'b1; in_vec = 3'b101; evt_ready = 1'b0; clr = 1'b0;

        // Reset, then a constant input never produces an event.
        add("t1_rst", 1, 3'b101, 0, 0, 0, 11'd0, 8'd0, 0, 3'd0);
        for (int i = 0; i < 10; i++)
            add("t1_hold", 0, 3'b101, 0, 0, 0, 11'd0, 8'd0, 0, 3'd0);
        // Fresh reset; INIT edge leaves ts=1, four more idle edges reach ts=5.
        add("t2_rst", 1, 3'b000, 0, 0, 0, 11'd0, 8'd0, 0, 3'd0);
        for (int i = 0; i < 5; i++)
            add("t2_idle", 0, 3'b000, 0, 0, 0, 11'd0, 8'd0, 0, 3'd0);
        // Change detected at ts=5; ready is high but FIFO was empty, so no pop yet.
        add("t2_push", 0, 3'b011, 1, 0, 1, {8'd5, 3'b011}, 8'd1, 0, 3'd1);
        add("t2_pop",  0, 3'b011, 1, 0, 0, 11'd0, 8'd1, 0, 3'd0);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].iv, vq[i].rdy, vq[i].cl);
            expect_out(vq[i].nm, vq[i].ev, vq[i].ed, vq[i].ec, vq[i].eo, vq[i].el);
        end

        // Six changes with no consumer (detect ts 7..12); head must stay {7,100}.
        step(0, 3'b100, 0, 0); expect_out("t3_c1", 1, {8'd7, 3'b100}, 8'd2, 0, 3'd1);
        step(0, 3'b101, 0, 0); expect_out("t3_c2", 1, {8'd7, 3'b100}, 8'd3, 0, 3'd2);
        step(0, 3'b110, 0, 0); expect_out("t3_c3", 1, {8'd7, 3'b100}, 8'd4, 0, 3'd3);
        step(0, 3'b111, 0, 0); expect_out("t3_c4", 1, {8'd7, 3'b100}, 8'd5, 0, 3'd4);
        step(0, 3'b000, 0, 0); expect_out("t3_c5", 1, {8'd7, 3'b100}, 8'd6, 1, 3'd4);
        step(0, 3'b001, 0, 0); expect_out("t3_c6", 1, {8'd7, 3'b100}, 8'd7, 1, 3'd4);

        // clr on a change edge (ts=13) with count=7, overflow=1: clr wins, FIFO intact.
        step(0, 3'b010, 0, 1); expect_out("t5_clr", 1, {8'd7, 3'b100}, 8'd0, 0, 3'd4);

        // Full FIFO, change at ts=14 with ready: pop and push together.
        step(0, 3'b011, 1, 0); expect_out("t4_fullpp", 1, {8'd8, 3'b101}, 8'd1, 0, 3'd4);
        step(0, 3'b011, 1, 0); expect_out("t4_drain1", 1, {8'd9, 3'b110}, 8'd1, 0, 3'd3);
        step(0, 3'b011, 1, 0); expect_out("t4_drain2", 1, {8'd10, 3'b111}, 8'd1, 0, 3'd2);
        step(0, 3'b011, 1, 0); expect_out("t4_drain3", 1, {8'd14, 3'b011}, 8'd1, 0, 3'd1);
        step(0, 3'b011, 1, 0); expect_out("t4_empty", 0, 11'd0, 8'd1, 0, 3'd0);

        // Fill to level 3 (detect ts 19..21), then reset mid-stream.
        step(0, 3'b100, 0, 0); expect_out("t6_f1", 1, {8'd19, 3'b100}, 8'd2, 0, 3'd1);
        step(0, 3'b101, 0, 0); expect_out("t6_f2", 1, {8'd19, 3'b100}, 8'd3, 0, 3'd2);
        step(0, 3'b110, 0, 0); expect_out("t6_f3", 1, {8'd19, 3'b100}, 8'd4, 0, 3'd3);
        step(1, 3'b111, 0, 0); expect_out("t6_rst", 0, 11'd0, 8'd0, 0, 3'd0);
        step(0, 3'b111, 0, 0); expect_out("t6_init", 0, 11'd0, 8'd0, 0, 3'd0);
        step(0, 3'b111, 0, 0); expect_out("t6_hold", 0, 11'd0, 8'd0, 0, 3'd0);
        step(0, 3'b010, 0, 0); expect_out("t6_ts", 1, {8'd2, 3'b010}, 8'd1, 0, 3'd1);

        // Count saturation and timestamp wrap: 260 toggles with a ready consumer.
        step(1, 3'b000, 1, 0); expect_out("sat_rst", 0, 11'd0, 8'd0, 0, 3'd0);
        step(0, 3'b000, 1, 0);
        for (int k = 0; k < 260; k++) begin
            step(0, (k % 2 == 1) ? 3'b000 : 3'b001, 1, 0);
            if (k == 253) chk("sat_mid.count", {24'd0, evt_count}, 32'd254);
        end
        expect_out("sat_end", 1, {8'd4, 3'b000}, 8'd255, 0, 3'd1);
        step(0, 3'b000, 1, 1); expect_out("sat_clr", 0, 11'd0, 8'd0, 0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
